decoder_rr_arbiter: RTL
=======================

// Module: decoder_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the 8-way one-hot select decoder between 8 requesters.
//  - Produces a registered 3-bit grant index, which drives the decoder select lines (in1=MSB .. in3=LSB).
//  - Produces a registered one-hot grant that equals the decoder output.
//  - Grant is held until the owner finishes, drops its request, or exceeds a hold limit.
//  - Break-before-make: a dead cycle sits between successive grants, so two one-hot bits are never high together.
// PARAMETERS
//  N_REQ     8   number of requesters; fixed to 8 to match the 3-bit decoder select
//  IDX_W     3   grant index width, equal to log2(N_REQ)
//  MAX_HOLD  15  maximum consecutive OWN cycles per grant, 1..255
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  req          in   8      request vector; bit i = requester i
//  done         in   1      the current owner finishes; sampled in OWN only
//  grant_valid  out  1      a grant is active (state OWN)
//  grant_idx    out  3      index of the current owner; feeds the decoder select
//  grant_oh     out  8      one-hot grant = 1<<grant_idx when grant_valid, else 0
//  timeout      out  1      one-cycle pulse: the grant was revoked by the hold limit
// BEHAVIOUR
//  Reset (asynchronous, immediate, including mid-grant):
//  - state=IDLE, ptr=0, hold_cnt=0.
//  - grant_valid=0, grant_idx=0, grant_oh=0, timeout=0.
//  States: IDLE, OWN, with registered outputs.
//  IDLE:
//  - If |req, pick the first set bit scanning ptr, ptr+1, ... mod 8.
//  - Next cycle: state=OWN, grant_idx=pick, grant_oh=1<<pick, grant_valid=1, hold_cnt=0.
//  - Latency from req sampled high to grant_valid high is 1 clock.
//  - If req==0, stay in IDLE with outputs 0; grant_idx holds its last value.
//  OWN:
//  - hold_cnt increments each cycle.
//  - Exit when done=1, or req[grant_idx]=0, or hold_cnt==MAX_HOLD-1.
//  - On exit, next cycle: state=IDLE, grant_valid=0, grant_oh=0, ptr=grant_idx+1 (7 wraps to 0).
//  - The earliest next grant is 2 cycles after the exit condition (one dead cycle).
//  Simultaneous exit conditions:
//  - done, or dropped request, together with the limit: a normal exit, timeout stays 0.
//  - Only a limit exit pulses timeout=1, in the same cycle grant_valid falls.
//  Other rules:
//  - Requests arriving for other bits during OWN are ignored until the next IDLE cycle; no preemption.
//  - A requester that is granted and still requests after exit is lowest priority next round, because ptr moved past it.
//  - All 8 requesting continuously: grants run 0,1,...,7,0 with a dead cycle between each.
//  - MAX_HOLD=1: every grant lasts exactly 1 OWN cycle; timeout pulses unless done or drop occurs in that cycle.
//  - hold_cnt width is $clog2(MAX_HOLD+1); it saturates and never wraps.
//  - Invariant: grant_oh is always 0 or exactly one-hot; grant_oh!=0 iff grant_valid.
// STRUCTURE
//  - Shared include arb_defs.vh holds: state encodings (ST_IDLE=1'b0, ST_OWN=1'b1), N_REQ, IDX_W.
//  - Sub-module rr_pick (combinational): inputs req[7:0], ptr[2:0]; outputs any, pick[2:0].
//  - rr_pick is a rotate, then a fixed-priority encoder, then an un-rotate.
//  - Top level holds the FSM, ptr, hold_cnt and output registers; every case/if fully assigns defaults (no latches).
// TESTING
//  1 Reset: rst_n=0 while OWN with idx=5 -> outputs 0 immediately, without waiting for a clock; after release, req=8'h20 -> grant_idx=5 at +1 clk.
//  2 Rotation: req=8'hFF held, done pulsed each OWN cycle -> grant_idx 0,1,2..7,0; grant_valid toggles 1,0; grant_oh never multi-hot.
//  3 Fairness: after a grant to idx 3, req=8'h88 -> next grant idx 7, then idx 3.
//  4 Timeout: MAX_HOLD=15, req=8'h04 held, done=0 -> 15 OWN cycles, timeout=1 on the cycle grant_valid falls; regrant to 2 after 1 dead cycle.
//  5 Drop/simultaneous: owner drops req -> exit, timeout=0; done and limit in the same cycle -> timeout=0.
//  6 Idle: req=0 for 20 cycles -> grant_valid=0, grant_oh=0 throughout; ptr unchanged.

Source files
------------

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter that drives the 8-way one-hot select decoder.
package decoder_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate by ptr, find the lowest set bit, then add ptr back.
module rr_pick
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    // Descending scan so the lowest set bit (closest to ptr) wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any  = |req;
    pick = ptr + off;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter with break-before-make grants, a hold limit and registered decoder outputs.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_oh,
  output logic             timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [N_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic              timeout_q, timeout_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              hold_limit;
  logic              owner_req;

  rr_pick u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .any  (pick_any),
    .pick (pick_idx)
  );

  assign hold_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign owner_req  = req[grant_idx_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    grant_oh_d    = grant_oh_q;
    timeout_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hold_cnt_d    = '0;
        grant_valid_d = 1'b0;
        grant_oh_d    = '0;
        if (pick_any) begin
          state_d       = ST_OWN;
          grant_idx_d   = pick_idx;
          grant_oh_d    = N_REQ'(1) << pick_idx;
          grant_valid_d = 1'b1;
        end
      end
      ST_OWN: begin
        // A limit exit only counts as a timeout when no normal exit coincides with it.
        if (done || !owner_req || hold_limit) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          grant_oh_d    = '0;
          ptr_d         = grant_idx_q + IDX_W'(1);
          hold_cnt_d    = '0;
          timeout_d     = hold_limit && !done && owner_req;
        end else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_oh_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_oh_q    <= grant_oh_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign grant_oh    = grant_oh_q;
  assign timeout     = timeout_q;

endmodule
